// File: rtl/al_accel_pkg.sv
// Shared types and sizes for the al_accel_mac job sequencer and its tile loader.
package al_accel_pkg;

    localparam int MAC_TAPS = 3;
    localparam int MAC_WIN  = 8;
    localparam int WORD_W   = 32;
    localparam int WGT_W    = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        COMPUTE = 3'd2,
        HANDOFF = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/al_accel_tile_loader.sv
// Tile fetch engine: issues MAC_WIN sequential word reads and captures each
// returned word into its window slot one cycle after the read.
module al_accel_tile_loader
    import al_accel_pkg::*;
#(
    parameter int AW = 16
)
(
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           init,
    input  logic                           rearm,
    input  logic                           active,
    input  logic                           abort,
    input  logic [AW-1:0]                  base,
    input  logic [WORD_W-1:0]              mem_rdata,
    output logic                           mem_rd,
    output logic [AW-1:0]                  mem_addr,
    output logic                           fetch_last,
    output logic [MAC_WIN-1:0][WORD_W-1:0] win
);

    localparam int KW = $clog2(MAC_WIN);

    logic [KW:0]   k_q;
    logic [AW-1:0] addr_q;
    logic          cap_vld_q;
    logic [KW-1:0] cap_k_q;

    // k_q[KW] set means all reads of this tile have been issued.
    assign mem_rd     = active && !abort && !k_q[KW];
    assign mem_addr   = addr_q;
    assign fetch_last = cap_vld_q && (cap_k_q == KW'(MAC_WIN - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            k_q       <= '0;
            addr_q    <= '0;
            cap_vld_q <= 1'b0;
            cap_k_q   <= '0;
            win       <= '0;
        end else begin
            cap_vld_q <= mem_rd;
            cap_k_q   <= k_q[KW-1:0];
            if (cap_vld_q) begin
                win[cap_k_q] <= mem_rdata;
            end
            // The address keeps counting across tiles, so the next tile starts
            // where the previous one ended; only a new job reloads it.
            if (init) begin
                addr_q <= base;
                k_q    <= '0;
            end else if (rearm) begin
                k_q <= '0;
            end else if (mem_rd) begin
                k_q    <= k_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/al_accel_mac_seq.sv
// Job sequencer for the al_accel_mac datapath: fetch tile, run MAC, hand off result.
// Optional AL_MAC_SEQ_PERF_EN adds a saturating HANDOFF stall counter (perf_stall).
module al_accel_mac_seq
    import al_accel_pkg::*;
#(
    parameter int AW      = 16,
    parameter int TW      = 8,
    parameter int MAC_LAT = 4
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [AW-1:0]     cfg_base,
    input  logic [TW-1:0]     cfg_ntiles,
    input  logic [WGT_W-1:0]  cfg_w0,
    input  logic [WGT_W-1:0]  cfg_w1,
    input  logic [WGT_W-1:0]  cfg_w2,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WGT_W-1:0]  mac_wdi_0,
    output logic [WGT_W-1:0]  mac_wdi_1,
    output logic [WGT_W-1:0]  mac_wdi_2,
    output logic [WORD_W-1:0] mac_idi_0,
    output logic [WORD_W-1:0] mac_idi_1,
    output logic [WORD_W-1:0] mac_idi_2,
    output logic [WORD_W-1:0] mac_idi_3,
    output logic [WORD_W-1:0] mac_idi_4,
    output logic [WORD_W-1:0] mac_idi_5,
    output logic [WORD_W-1:0] mac_idi_6,
    output logic [WORD_W-1:0] mac_idi_7,
    output logic              mac_enb,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [TW-1:0]     tile_idx,
    output logic              busy,
    output logic              done
`ifdef AL_MAC_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_stall
`endif
);

    localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t                        state_q, state_d;
    logic [TW-1:0]                 ntiles_q;
    logic [TW-1:0]                 tile_q;
    logic [LW-1:0]                 lat_q;
    logic                          accept;
    logic                          handshake;
    logic                          last_tile;
    logic                          fetch_last;
    logic [MAC_WIN-1:0][WORD_W-1:0] win;

    assign accept    = (state_q == IDLE) && start;
    assign handshake = (state_q == HANDOFF) && tile_ready && !abort;
    assign last_tile = (tile_q == (ntiles_q - 1'b1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_ntiles == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort)           state_d = IDLE;
                else if (fetch_last) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (abort)             state_d = IDLE;
                else if (lat_q == '0)  state_d = HANDOFF;
            end
            HANDOFF: begin
                if (abort)           state_d = IDLE;
                else if (tile_ready) state_d = last_tile ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort wins over every handshake or phase exit in the same cycle.
    always_comb begin
        mac_enb    = (state_q == COMPUTE) && !abort;
        tile_valid = (state_q == HANDOFF) && !abort;
        done       = (state_q == DONE) && !abort;
        busy       = (state_q != IDLE);
        tile_idx   = tile_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ntiles_q  <= '0;
            tile_q    <= '0;
            mac_wdi_0 <= '0;
            mac_wdi_1 <= '0;
            mac_wdi_2 <= '0;
        end else if (accept) begin
            ntiles_q  <= cfg_ntiles;
            tile_q    <= '0;
            mac_wdi_0 <= cfg_w0;
            mac_wdi_1 <= cfg_w1;
            mac_wdi_2 <= cfg_w2;
        end else if (handshake) begin
            tile_q <= tile_q + 1'b1;
        end
    end

    // MAC latency down-counter, armed throughout FETCH so COMPUTE starts full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lat_q <= '0;
        end else if (state_q == FETCH) begin
            lat_q <= LW'(MAC_LAT - 1);
        end else if ((state_q == COMPUTE) && (lat_q != '0)) begin
            lat_q <= lat_q - 1'b1;
        end
    end

    al_accel_tile_loader #(
        .AW (AW)
    ) u_loader (
        .clk        (clk),
        .resetn     (resetn),
        .init       (accept),
        .rearm      (handshake && !last_tile),
        .active     (state_q == FETCH),
        .abort      (abort),
        .base       (cfg_base),
        .mem_rdata  (mem_rdata),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .fetch_last (fetch_last),
        .win        (win)
    );

    assign mac_idi_0 = win[0];
    assign mac_idi_1 = win[1];
    assign mac_idi_2 = win[2];
    assign mac_idi_3 = win[3];
    assign mac_idi_4 = win[4];
    assign mac_idi_5 = win[5];
    assign mac_idi_6 = win[6];
    assign mac_idi_7 = win[7];

`ifdef AL_MAC_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if ((state_q == HANDOFF) && !tile_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_al_accel_mac_seq.sv
// Self-checking bench for al_accel_mac_seq: vector table, directed abort/reset
// sequences and random jobs checked against an arithmetic model of the job timing.
module tb_al_accel_mac_seq;

    localparam int AW      = 16;
    localparam int TW      = 8;
    localparam int MAC_LAT = 4;

    logic          clk = 1'b0;
    logic          resetn, start, abort, tile_ready;
    logic [AW-1:0] cfg_base;
    logic [TW-1:0] cfg_ntiles;
    logic [7:0]    cfg_w0, cfg_w1, cfg_w2;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic [7:0]    mac_wdi_0, mac_wdi_1, mac_wdi_2;
    logic [31:0]   idi [8];
    logic          mac_enb, tile_valid, busy, done;
    logic [TW-1:0] tile_idx;
`ifdef AL_MAC_SEQ_PERF_EN
    logic [31:0]   perf_stall;
`endif

    logic [31:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    al_accel_mac_seq #(.AW(AW), .TW(TW), .MAC_LAT(MAC_LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .cfg_base   (cfg_base),
        .cfg_ntiles (cfg_ntiles),
        .cfg_w0     (cfg_w0),
        .cfg_w1     (cfg_w1),
        .cfg_w2     (cfg_w2),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mac_wdi_0  (mac_wdi_0),
        .mac_wdi_1  (mac_wdi_1),
        .mac_wdi_2  (mac_wdi_2),
        .mac_idi_0  (idi[0]),
        .mac_idi_1  (idi[1]),
        .mac_idi_2  (idi[2]),
        .mac_idi_3  (idi[3]),
        .mac_idi_4  (idi[4]),
        .mac_idi_5  (idi[5]),
        .mac_idi_6  (idi[6]),
        .mac_idi_7  (idi[7]),
        .mac_enb    (mac_enb),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .done       (done)
`ifdef AL_MAC_SEQ_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    typedef struct {
        logic [15:0] base;
        logic [7:0]  ntiles;
        int          stall;
        bit          hold;
        logic [7:0]  w0, w1, w2;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_addr(input logic [15:0] base, input int t, input int k);
        return 16'(int'(base) + 8 * t + k);
    endfunction

    function automatic logic [31:0] idi_or();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r |= idi[i];
        return r;
    endfunction

    // One complete job; the bench releases tile_ready after 'stall' valid cycles per tile.
    task automatic run_job(input logic [15:0] base, input logic [7:0] nt, input int stall,
                           input bit hold, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input int exp_lat, input string tag);
        logic [15:0] addrs[$];
        int enb = 0, dones = 0, done_cyc = -1, vcnt = 0, seen = 0, bad = 0;
        @(negedge clk);
        cfg_base = base; cfg_ntiles = nt; cfg_w0 = w0; cfg_w1 = w1; cfg_w2 = w2;
        start = 1'b1; tile_ready = 1'b0;
        for (int cyc = 1; cyc <= 1200; cyc++) begin
            @(negedge clk);
            if (mem_rd) addrs.push_back(mem_addr);
            if (mac_enb) enb++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                check({tag, "_busy_at_done"}, busy, 1);
            end
            tile_ready = 1'b0;
            if (tile_valid) begin
                if (vcnt >= stall) begin
                    tile_ready = 1'b1;
                    check({tag, "_tile_idx"}, tile_idx, seen);
                    for (int k = 0; k < 8; k++)
                        check({tag, "_idi"}, idi[k], mem[model_addr(base, seen, k)]);
                    check({tag, "_wdi"}, {mac_wdi_0, mac_wdi_1, mac_wdi_2}, {w0, w1, w2});
                    seen++;
                    vcnt = 0;
                end else begin
                    vcnt++;
                end
            end
            if (!hold || dones > 0) start = 1'b0;
            if (dones > 0 && cyc > done_cyc + 10) break;
        end
        start = 1'b0;
        tile_ready = 1'b0;
        check({tag, "_done_cnt"}, dones, 1);
        check({tag, "_latency"}, done_cyc, exp_lat);
        check({tag, "_rd_cnt"}, addrs.size(), int'(nt) * 8);
        for (int i = 0; i < addrs.size() && i < int'(nt) * 8; i++)
            if (addrs[i] !== model_addr(base, i / 8, i % 8)) bad++;
        check({tag, "_addr_seq"}, bad, 0);
        check({tag, "_enb_cycles"}, enb, int'(nt) * MAC_LAT);
        check({tag, "_tiles"}, seen, nt);
        check({tag, "_idle_after"}, busy, 0);
`ifdef AL_MAC_SEQ_PERF_EN
        check({tag, "_perf_stall"}, perf_stall, int'(nt) * stall);
`endif
    endtask

    initial begin
        int cnt;
        int bad;
        logic [15:0] rb;
        logic [7:0]  rn;
        int          rs;

        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h10] = 32'd0;   mem[16'h11] = 32'd10;
        mem[16'h12] = -32'sd20; mem[16'h13] = -32'sd10;
        mem[16'h14] = 32'd30;  mem[16'h15] = 32'd40;
        mem[16'h16] = 32'd10;  mem[16'h17] = 32'd20;

        vecs[0] = '{16'h0010, 8'd1, 0, 1'b0, 8'hF6, 8'h40, 8'h80, 15};
        vecs[1] = '{16'h0010, 8'd3, 5, 1'b0, 8'h01, 8'h02, 8'h03, 58};
        vecs[2] = '{16'h0010, 8'd0, 0, 1'b0, 8'h11, 8'h22, 8'h33, 1};
        vecs[3] = '{16'hFFFC, 8'd1, 0, 1'b0, 8'h7F, 8'h81, 8'h00, 15};
        vecs[4] = '{16'h0200, 8'd2, 1, 1'b1, 8'hAA, 8'h55, 8'hC3, 31};

        resetn = 1'b0; start = 1'b0; abort = 1'b0; tile_ready = 1'b0;
        cfg_base = '0; cfg_ntiles = '0; cfg_w0 = '0; cfg_w1 = '0; cfg_w2 = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {mem_rd, mem_addr, mac_enb, tile_valid, tile_idx, busy, done}, 0);
        check("reset_idi", idi_or(), 0);
        check("reset_wdi", {mac_wdi_0, mac_wdi_1, mac_wdi_2}, 0);
        resetn = 1'b1;

        for (int v = 0; v < 5; v++)
            run_job(vecs[v].base, vecs[v].ntiles, vecs[v].stall, vecs[v].hold,
                    vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].exp_lat, $sformatf("vec%0d", v));

        // Abort in the second COMPUTE cycle.
        @(negedge clk);
        cfg_base = 16'h0040; cfg_ntiles = 8'd2; start = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 100 && cnt < 2; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mac_enb) cnt++;
        end
        check("abort_reach_compute", cnt, 2);
        abort = 1'b1;
        #1;
        check("abort_enb_forced_low", mac_enb, 0);
        check("abort_busy_same_cycle", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_next", busy, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || mac_enb || mem_rd || tile_valid || busy) bad++;
        end
        check("abort_quiet", bad, 0);
        run_job(16'h0300, 8'd1, 2, 1'b0, 8'h01, 8'hFF, 8'h10, 17, "post_abort");

        // Reset in the middle of FETCH.
        @(negedge clk);
        cfg_base = 16'h0080; cfg_ntiles = 8'd1; start = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 100 && cnt < 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_rd) cnt++;
        end
        check("reset_reach_fetch", cnt, 4);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_ctrl", {mem_rd, mem_addr, mac_enb, tile_valid, tile_idx, busy, done}, 0);
        check("midreset_idi", idi_or(), 0);
        check("midreset_wdi", {mac_wdi_0, mac_wdi_1, mac_wdi_2}, 0);
        resetn = 1'b1;

        // Random jobs: latency model is ntiles * (fetch 9 + MAC_LAT + handoff 1 + stall) + done 1.
        for (int j = 0; j < 6; j++) begin
            rb = 16'($urandom_range(0, 65535));
            rn = 8'($urandom_range(1, 3));
            rs = $urandom_range(0, 3);
            run_job(rb, rn, rs, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
                    int'(rn) * (9 + MAC_LAT + 1 + rs) + 1, $sformatf("rnd%0d", j));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
